// File: rtl/ifmap_fetch_unit.sv
// Purpose: ifmap fetch - linearise (n,c,row,col) tuples to scratchpad reads, return data in order.
// Latency: out_valid rises MEM_LAT+1 cycles after the accept edge when the output FIFO is empty.
// Backpressure: await stalls the generator once reads in flight plus FIFO entries reach FIFO_DEPTH.

module ifmap_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  output logic          rd_vld,
  output logic [DW-1:0] rd_dat,
  input  logic          rd_rdy
);
  // Generic FIFO: head is combinational from storage, write and pop may coincide.
  // Latency: one cycle from write to rd_vld.
  // Backpressure: none internally; the writer must never push when full.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop;

  assign rd_vld = (count != '0);
  assign rd_dat = store[rd_ptr];
  assign pop    = rd_vld & rd_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (wr_vld) begin
        store[wr_ptr] <= wr_dat;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_vld, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module ifmap_fetch_unit #(
  parameter int N_WIDTH    = 3,
  parameter int C_WIDTH    = 10,
  parameter int H_WIDTH    = 8,
  parameter int W_WIDTH    = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  gen_done,
  input  logic                  idx_valid,
  input  logic [N_WIDTH-1:0]    ifmap_index,
  input  logic [C_WIDTH-1:0]    channel_index,
  input  logic [H_WIDTH-1:0]    row_index,
  input  logic [W_WIDTH-1:0]    col_index,
  input  logic [C_WIDTH-1:0]    C,
  input  logic [H_WIDTH-1:0]    H,
  input  logic [W_WIDTH-1:0]    W,
  output logic                  await,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PROD_W = N_WIDTH + C_WIDTH + H_WIDTH + W_WIDTH + 3;

  state_t              state;
  state_t              state_nxt;
  logic [OCC_W-1:0]    occ;
  logic                active;
  logic                accept;
  logic                pop;
  logic [MEM_LAT-1:0]  tag_pipe;
  logic [PROD_W-1:0]   addr_full;

  assign active = (state == RUN) || (state == DRAIN);
  // occ counts slots already promised to the FIFO, so a full occ means no room for another read
  assign await  = active && (occ == OCC_W'(FIFO_DEPTH));
  assign accept = idx_valid && !await && (state == RUN);
  assign pop    = out_valid && out_ready;
  assign busy   = active;
  assign done   = (state == DONE);

  always_comb begin
    addr_full = ((PROD_W'(ifmap_index) * PROD_W'(C) + PROD_W'(channel_index)) * PROD_W'(H)
                 + PROD_W'(row_index)) * PROD_W'(W) + PROD_W'(col_index);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = RUN;
      RUN:     if (gen_done)    state_nxt = DRAIN;
      DRAIN:   if (occ == '0)   state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      mem_rd_en <= accept;
      if (accept) mem_addr <= ADDR_WIDTH'(addr_full);
    end
  end

  // Each issued read carries a tag that surfaces exactly when its data is on mem_rd_data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= mem_rd_en;
      for (int i = 1; i < MEM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  ifmap_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DATA_WIDTH)
  ) u_out_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (tag_pipe[MEM_LAT-1]),
    .wr_dat (mem_rd_data),
    .rd_vld (out_valid),
    .rd_dat (out_data),
    .rd_rdy (out_ready)
  );

endmodule

// File: tb/tb_ifmap_fetch_unit.sv
// Bench for ifmap_fetch_unit: random tuples and consumer stalls against a queue-based reference model.
module tb_ifmap_fetch_unit;
  localparam int MEM_LAT = 2;
  localparam int DEPTH   = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, gen_done, idx_valid, out_ready;
  logic [2:0]  ifmap_index;
  logic [9:0]  channel_index, C;
  logic [7:0]  row_index, col_index, H, W;
  logic        await, mem_rd_en, out_valid, busy, done;
  logic [15:0] mem_addr, mem_rd_data, out_data;

  ifmap_fetch_unit #(
    .N_WIDTH(3), .C_WIDTH(10), .H_WIDTH(8), .W_WIDTH(8),
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LAT(MEM_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .gen_done(gen_done), .idx_valid(idx_valid),
    .ifmap_index(ifmap_index), .channel_index(channel_index), .row_index(row_index),
    .col_index(col_index), .C(C), .H(H), .W(W), .await(await), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done)
  );

  typedef struct {int n; int c; int r; int w;} tup_t;
  typedef struct {longint due; logic [15:0] dat;} pend_t;

  tup_t        tq[$];
  pend_t       pend[$];
  logic [15:0] fifo_q[$];
  logic [15:0] popped[$];
  int          obs_addr[$];
  logic [15:0] mem_img [65536];

  int     n_chk = 0, n_err = 0;
  int     st = S_IDLE;
  bit     exp_rd_en = 0;
  logic [15:0] exp_addr = '0;
  longint cyc = 0, acc_cyc = -1, rise_cyc = -1;
  int     done_cnt = 0;
  int     ready_mode = 1;
  bit     gap_en = 0, pop_once = 0;
  bit     ml_v [MEM_LAT+1];
  int     ml_a [MEM_LAT+1];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] addr_model(input longint n, c, r, w, cc, hh, ww);
    longint full;
    full = ((n * cc + c) * hh + r) * ww + w;
    return full[15:0];
  endfunction

  // Scratchpad, reference model and per-cycle output checks, all away from the active edge
  always @(negedge clk) begin
    int occ;
    bit acc;
    logic [15:0] a;
    cyc++;
    for (int i = MEM_LAT; i > 0; i--) begin ml_v[i] = ml_v[i-1]; ml_a[i] = ml_a[i-1]; end
    ml_v[0] = mem_rd_en;
    ml_a[0] = int'(mem_addr);
    mem_rd_data = ml_v[MEM_LAT] ? mem_img[ml_a[MEM_LAT]] : 16'($urandom);
    if (reset) begin
      chk("rst_await", await, 0);      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_addr", mem_addr, 0);    chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0); chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      pend.delete(); fifo_q.delete(); exp_rd_en = 0; st = S_IDLE;
    end else begin
      while (pend.size() > 0 && pend[0].due <= cyc) begin
        fifo_q.push_back(pend[0].dat);
        pend.delete(0);
      end
      occ = pend.size() + fifo_q.size();
      chk("busy", busy, st == S_RUN || st == S_DRAIN);
      chk("done", done, st == S_DONE);
      chk("await", await, (st == S_RUN || st == S_DRAIN) && occ == DEPTH);
      chk("rd_en", mem_rd_en, exp_rd_en);
      if (exp_rd_en) chk("addr", mem_addr, exp_addr);
      chk("out_valid", out_valid, fifo_q.size() != 0);
      if (fifo_q.size() != 0) chk("out_data", out_data, fifo_q[0]);
      if (mem_rd_en) obs_addr.push_back(int'(mem_addr));
      if (done) done_cnt++;
      if (out_valid && rise_cyc < 0) rise_cyc = cyc;
      if (out_valid && out_ready) popped.push_back(out_data);
      if (fifo_q.size() != 0 && out_ready) fifo_q.delete(0);
      acc = (st == S_RUN) && idx_valid && (occ != DEPTH);
      exp_rd_en = acc;
      if (acc) begin
        a = addr_model(ifmap_index, channel_index, row_index, col_index, C, H, W);
        exp_addr = a;
        pend.push_back('{cyc + MEM_LAT + 2, mem_img[a]});
        if (tq.size() > 0) tq.delete(0);
        if (acc_cyc < 0) acc_cyc = cyc;
      end
      case (st)
        S_IDLE:  if (start) st = S_RUN;
        S_RUN:   if (gen_done) st = S_DRAIN;
        S_DRAIN: if (occ == 0) st = S_DONE;
        default: st = S_IDLE;
      endcase
    end
  end

  // Generator and consumer driver
  always @(posedge clk) begin
    #1;
    if (tq.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
      idx_valid = 1'b1;
      ifmap_index = 3'(tq[0].n); channel_index = 10'(tq[0].c);
      row_index = 8'(tq[0].r);   col_index = 8'(tq[0].w);
    end else begin
      idx_valid = 1'b0;
      ifmap_index = 3'($urandom); channel_index = 10'($urandom);
      row_index = 8'($urandom);   col_index = 8'($urandom);
    end
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = !out_ready;
      default: out_ready = 1'($urandom);
    endcase
    if (pop_once) begin out_ready = 1'b1; pop_once = 0; end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic clear_obs();
    popped.delete(); obs_addr.delete();
    done_cnt = 0; acc_cyc = -1; rise_cyc = -1;
  endtask

  task automatic wait_q_empty(input string tag);
    int k = 0;
    while (tq.size() > 0 && k < 3000) begin step(1); k++; end
    chk({tag, "_tuples_taken"}, tq.size(), 0);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (st != S_IDLE && k < 500) begin step(1); k++; end
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic finish_pass(input string tag);
    wait_q_empty(tag);
    gen_done = 1'b1; step(1); gen_done = 1'b0;
    wait_idle(tag);
  endtask

  task automatic push_small(input int n);
    repeat (n) tq.push_back('{int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                               int'($urandom_range(0, 3)), int'($urandom_range(0, 3))});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; gen_done = 1'b0; idx_valid = 1'b0; out_ready = 1'b0;
    mem_rd_data = '0; C = 10'd2; H = 8'd4; W = 8'd4;
    ifmap_index = '0; channel_index = '0; row_index = '0; col_index = '0;
    for (int i = 0; i < 65536; i++) mem_img[i] = 16'($urandom);
    step(3);
    reset = 1'b0;

    // Single read: address, data and latency; tuple offered in IDLE must wait for start
    clear_obs(); mem_img[59] = 16'hABCD; ready_mode = 1;
    tq.push_back('{1, 1, 2, 3});
    step(4);
    chk("t1_idle_ignored", obs_addr.size(), 0);
    pulse_start();
    finish_pass("t1");
    chk("t1_addr", obs_addr.size() > 0 ? obs_addr[0] : -1, 59);
    chk("t1_data", popped.size() > 0 ? popped[0] : -1, 16'hABCD);
    chk("t1_latency", rise_cyc - acc_cyc - 1, MEM_LAT + 1);

    // Stalled consumer: occupancy saturates at DEPTH, one pop releases one slot
    clear_obs(); ready_mode = 0; push_small(6);
    pulse_start(); step(12);
    chk("t2_accepts", obs_addr.size(), 4);
    chk("t2_await_full", await, 1);
    pop_once = 1; step(5);
    chk("t2_one_more", obs_addr.size(), 5);
    chk("t2_await_again", await, 1);
    ready_mode = 1;
    finish_pass("t2");
    chk("t2_pops", popped.size(), 6);

    // Ordered stream under a toggling consumer
    clear_obs(); C = 10'd2; H = 8'd4; W = 8'd16; ready_mode = 2;
    for (int i = 0; i < 16; i++) begin mem_img[i] = 16'(i); tq.push_back('{0, 0, 0, i}); end
    pulse_start();
    finish_pass("t3");
    chk("t3_count", popped.size(), 16);
    for (int i = 0; i < 16; i++) chk("t3_order", i < popped.size() ? popped[i] : -1, i);

    // Large dimensions: address wraps to the low 16 bits; stray start in RUN ignored
    clear_obs(); C = 10'd1023; H = 8'd255; W = 8'd255; ready_mode = 3; gap_en = 1;
    tq.push_back('{7, 1022, 254, 254});
    for (int i = 0; i < 39; i++)
      tq.push_back('{i < 20 ? 7 : int'($urandom_range(0, 7)), int'($urandom_range(0, 1022)),
                     int'($urandom_range(0, 254)), int'($urandom_range(0, 254))});
    pulse_start(); step(5); pulse_start();
    finish_pass("t4");
    chk("t4_trunc", obs_addr.size() > 0 ? obs_addr[0] : -1, 16'h2FF7);
    chk("t4_reads", obs_addr.size(), 40);
    chk("t4_pops", popped.size(), 40);
    gap_en = 0;

    // Drain with three entries pending when gen_done arrives
    clear_obs(); C = 10'd2; H = 8'd4; W = 8'd4; ready_mode = 0; push_small(3);
    pulse_start();
    wait_q_empty("t5");
    step(MEM_LAT + 3);
    chk("t5_pending", out_valid, 1);
    gen_done = 1'b1; ready_mode = 1; step(1); gen_done = 1'b0;
    wait_idle("t5");
    chk("t5_pops", popped.size(), 3);

    // Reset with reads in flight, then a clean pass
    clear_obs(); ready_mode = 0; push_small(3);
    pulse_start();
    begin
      int k = 0;
      while (obs_addr.size() < 2 && k < 100) begin step(1); k++; end
    end
    chk("t6_two_issued", obs_addr.size(), 2);
    reset = 1'b1; tq.delete(); #1;
    chk("t6_rd_en0", mem_rd_en, 0); chk("t6_busy0", busy, 0);
    chk("t6_valid0", out_valid, 0); chk("t6_addr0", mem_addr, 0);
    step(1); reset = 1'b0;
    step(8);
    chk("t6_no_push", out_valid, 0);
    clear_obs(); ready_mode = 3; push_small(5);
    pulse_start();
    finish_pass("t6b");
    chk("t6b_pops", popped.size(), 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end
endmodule
